// File: rtl/clksel_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clksel_ctrl
//
// Clock-select sequencer sitting in front of the glitch-free CPU clock mux.
// It decides when the CPU clock moves between the slow path (mux clk0) and
// the fast path (mux clk1), drives the mux select line and watches the mux
// active0/active1 feedback to confirm that the handover really happened.
// A switch is only launched once the 68000 bus has been idle (as_n high) for
// IDLE_CYCLES consecutive synchronised cycles. A switch that is not confirmed
// within TIMEOUT cycles is abandoned and flagged through the sticky err bit.
//
// Ports:
//   clk         free-running reference clock (unrelated to the mux clocks)
//   rst_n       asynchronous active-low reset
//   req_fast    control-register level, 1 = fast clock wanted
//   force_slow  level, 1 = slow clock required; overrides req_fast
//   as_n        asynchronous CPU address strobe, active low
//   active0     asynchronous mux feedback, slow path enabled
//   active1     asynchronous mux feedback, fast path enabled
//   err_clr     single-cycle pulse clearing err
//   select      mux select, 0 = clk0 (slow), 1 = clk1 (fast)
//   fast        1 only while settled on the fast clock
//   busy        1 while arming or switching
//   err         sticky switch-timeout flag
// -----------------------------------------------------------------------------
module clksel_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_fast,
  input  logic force_slow,
  input  logic as_n,
  input  logic active0,
  input  logic active1,
  input  logic err_clr,
  output logic select,
  output logic fast,
  output logic busy,
  output logic err
);

  localparam int IDLE_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam int TMR_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

  typedef enum logic [2:0] {
    S_SLOW  = 3'd0,
    S_ARM_F = 3'd1,
    S_SW_F  = 3'd2,
    S_FAST  = 3'd3,
    S_ARM_S = 3'd4,
    S_SW_S  = 3'd5
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [SYNC_STAGES-1:0] as_sync_r;
  logic [SYNC_STAGES-1:0] act0_sync_r;
  logic [SYNC_STAGES-1:0] act1_sync_r;
  logic                   as_s;
  logic                   act0_s;
  logic                   act1_s;

  logic [IDLE_W-1:0]      idle_cnt_r;
  logic [TMR_W-1:0]       tmr_r;

  logic                   want_fast;
  logic                   idle_ok;
  logic                   tmr_done_s;
  logic                   select_nxt_s;
  logic                   timeout_s;
  logic                   sw_nxt_s;
  logic                   sw_entry_s;

  // Synchroniser chains for the three asynchronous inputs. The address
  // strobe chain resets to 1 so a reset does not look like bus activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_sync_r   <= '1;
      act0_sync_r <= '0;
      act1_sync_r <= '0;
    end else begin
      as_sync_r   <= {as_sync_r[SYNC_STAGES-2:0], as_n};
      act0_sync_r <= {act0_sync_r[SYNC_STAGES-2:0], active0};
      act1_sync_r <= {act1_sync_r[SYNC_STAGES-2:0], active1};
    end
  end

  assign as_s   = as_sync_r[SYNC_STAGES-1];
  assign act0_s = act0_sync_r[SYNC_STAGES-1];
  assign act1_s = act1_sync_r[SYNC_STAGES-1];

  assign want_fast  = req_fast & ~force_slow;
  assign idle_ok    = (idle_cnt_r == IDLE_MAX);
  assign tmr_done_s = (tmr_r == TMR_MAX);

  // Bus-idle counter: any synchronised strobe restarts the idle window,
  // otherwise it counts up and parks at IDLE_CYCLES. It runs in every state
  // so a bus that has been quiet for a while allows an immediate launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= '0;
    end else if (!as_s) begin
      idle_cnt_r <= '0;
    end else if (idle_cnt_r != IDLE_MAX) begin
      idle_cnt_r <= idle_cnt_r + IDLE_ONE;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // Next-state decision. select is only ever changed on the launch of a
  // switch or on the revert after a fast-switch timeout.
  always_comb begin
    state_nxt_s  = state_r;
    select_nxt_s = select;
    timeout_s    = 1'b0;
    case (state_r)
      S_SLOW: begin
        if (want_fast) begin
          state_nxt_s = S_ARM_F;
        end else begin
          state_nxt_s = S_SLOW;
        end
      end
      S_ARM_F: begin
        if (!want_fast) begin
          state_nxt_s = S_SLOW;
        end else if (idle_ok) begin
          state_nxt_s  = S_SW_F;
          select_nxt_s = 1'b1;
        end else begin
          state_nxt_s = S_ARM_F;
        end
      end
      S_SW_F: begin
        // Both feedbacks low (handover gap) or both high: keep waiting.
        if (act1_s && !act0_s) begin
          state_nxt_s = S_FAST;
        end else if (tmr_done_s) begin
          // Abandon the fast switch and steer the mux back to clk0.
          timeout_s    = 1'b1;
          select_nxt_s = 1'b0;
          state_nxt_s  = S_SW_S;
        end else begin
          state_nxt_s = S_SW_F;
        end
      end
      S_FAST: begin
        if (!want_fast) begin
          state_nxt_s = S_ARM_S;
        end else begin
          state_nxt_s = S_FAST;
        end
      end
      S_ARM_S: begin
        if (want_fast) begin
          state_nxt_s = S_FAST;
        end else if (idle_ok) begin
          state_nxt_s  = S_SW_S;
          select_nxt_s = 1'b0;
        end else begin
          state_nxt_s = S_ARM_S;
        end
      end
      S_SW_S: begin
        if (act0_s && !act1_s) begin
          state_nxt_s = S_SLOW;
        end else if (tmr_done_s) begin
          // select is already 0 here; give up waiting and settle on SLOW.
          timeout_s    = 1'b1;
          select_nxt_s = 1'b0;
          state_nxt_s  = S_SLOW;
        end else begin
          state_nxt_s = S_SW_S;
        end
      end
      default: begin
        state_nxt_s  = S_SLOW;
        select_nxt_s = 1'b0;
      end
    endcase
  end

  // A switch state entered from any other state (including SW_F -> SW_S on
  // a revert) restarts the confirmation timer.
  always_comb begin
    sw_nxt_s   = 1'b0;
    sw_entry_s = 1'b0;
    if ((state_nxt_s == S_SW_F) || (state_nxt_s == S_SW_S)) begin
      sw_nxt_s   = 1'b1;
      sw_entry_s = (state_nxt_s != state_r);
    end else begin
      sw_nxt_s   = 1'b0;
      sw_entry_s = 1'b0;
    end
  end

  // Switch confirmation timer: counts cycles spent in a switch state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_r <= '0;
    end else if (sw_entry_s) begin
      tmr_r <= '0;
    end else if (sw_nxt_s && (tmr_r != TMR_MAX)) begin
      tmr_r <= tmr_r + TMR_ONE;
    end else if (sw_nxt_s) begin
      tmr_r <= tmr_r;
    end else begin
      tmr_r <= '0;
    end
  end

  // State register and registered outputs. fast and busy decode the next
  // state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_SLOW;
      select  <= 1'b0;
      fast    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      select  <= select_nxt_s;
      fast    <= (state_nxt_s == S_FAST);
      busy    <= (state_nxt_s == S_ARM_F) || (state_nxt_s == S_SW_F) ||
                 (state_nxt_s == S_ARM_S) || (state_nxt_s == S_SW_S);
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (timeout_s) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end else begin
        err <= err;
      end
    end
  end

endmodule

// File: tb/tb_clksel_ctrl.sv
`timescale 1ns/1ps
// Testbench for clksel_ctrl: random and directed stimulus, a behavioural
// reference model producing per-cycle expected outputs into a queue, and a
// monitor that pops and compares on every falling clock edge.
module tb_clksel_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int IDLE_CYCLES = 4;
  localparam int TIMEOUT     = 255;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic req_fast   = 1'b0;
  logic force_slow = 1'b0;
  logic as_n       = 1'b1;
  logic active0    = 1'b1;
  logic active1    = 1'b0;
  logic err_clr    = 1'b0;
  logic select, fast, busy, err;

  clksel_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_CYCLES(IDLE_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_fast  (req_fast),
    .force_slow(force_slow),
    .as_n      (as_n),
    .active0   (active0),
    .active1   (active1),
    .err_clr   (err_clr),
    .select    (select),
    .fast      (fast),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sel;
    logic fst;
    logic bsy;
    logic er;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model. phase: 0 settled, 1 waiting for bus idle, 2 waiting
  // for mux confirmation. m_dir: the clock settled on (phase 0) or the
  // clock being moved to (phases 1 and 2).
  int m_phase;
  bit m_dir, m_sel, m_err;
  int m_age;       // cycles already spent waiting for confirmation
  int m_run;       // consecutive synchronised idle samples seen so far
  bit as_line[$], a0_line[$], a1_line[$];

  // Mux behaviour: 0 normal, 1 frozen, 2 drops old path but never enables new
  int mux_stuck = 0;
  bit mux_tgt   = 1'b0;
  int mux_cnt   = 0;

  function automatic void model_reset();
    m_phase = 0; m_dir = 1'b0; m_sel = 1'b0; m_err = 1'b0;
    m_age = 0; m_run = 0;
    as_line.delete(); a0_line.delete(); a1_line.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      as_line.push_back(1'b1);
      a0_line.push_back(1'b0);
      a1_line.push_back(1'b0);
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.sel = m_sel;
    e.fst = (m_phase == 0) && m_dir;
    e.bsy = (m_phase != 0);
    e.er  = m_err;
    exp_q.push_back(e);
  endfunction

  // One clock edge of the specified behaviour, using the inputs present now.
  function automatic void model_step();
    bit as_s, a0_s, a1_s, want, idle_ok, timeout, ok;
    if (!rst_n) begin
      model_reset();
    end else begin
      as_s = as_line.pop_front(); as_line.push_back(as_n);
      a0_s = a0_line.pop_front(); a0_line.push_back(active0);
      a1_s = a1_line.pop_front(); a1_line.push_back(active1);
      want    = req_fast && !force_slow;
      idle_ok = (m_run >= IDLE_CYCLES);
      if (!as_s) m_run = 0;
      else if (m_run < 1000) m_run = m_run + 1;
      timeout = 1'b0;
      if (m_phase == 0) begin
        if (want != m_dir) begin
          m_phase = 1;
          m_dir   = want;
        end
      end else if (m_phase == 1) begin
        if (want != m_dir) begin
          m_phase = 0;
          m_dir   = want;
        end else if (idle_ok) begin
          m_phase = 2;
          m_sel   = m_dir;
          m_age   = 0;
        end
      end else begin
        ok = m_dir ? (a1_s && !a0_s) : (a0_s && !a1_s);
        if (ok) begin
          m_phase = 0;
        end else if (m_age == TIMEOUT) begin
          timeout = 1'b1;
          m_sel   = 1'b0;
          m_age   = 0;
          if (m_dir) m_dir = 1'b0;   // revert: now waiting for the slow path
          else m_phase = 0;          // give up and call it slow
        end else begin
          m_age = m_age + 1;
        end
      end
      if (timeout) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    push_expected();
  endfunction

  // Mux stand-in following the model's select: drops the old path first,
  // enables the new one 2..5 cycles after the select change.
  function automatic void mux_update();
    if (m_sel != mux_tgt) begin
      mux_tgt = m_sel;
      mux_cnt = int'($urandom_range(5, 2));
    end else if (mux_cnt > 0) begin
      mux_cnt = mux_cnt - 1;
      if (mux_stuck != 1) begin
        if (mux_tgt) active0 = 1'b0;
        else active1 = 1'b0;
        if (mux_cnt == 0 && mux_stuck == 0) begin
          active0 = ~mux_tgt;
          active1 = mux_tgt;
        end
      end
    end
  endfunction

  function automatic void unstick();
    mux_stuck = 0;
    mux_cnt   = 0;
    active0   = ~mux_tgt;
    active1   = mux_tgt;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    mux_update();
    cyc = cyc + 1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Bounded wait for the DUT to settle on the given clock.
  task automatic wait_settled(input string name, input bit f, input int budget);
    int n;
    n = 0;
    while (!(fast === f && busy === 1'b0 && select === f) && n < budget) begin
      cycle();
      n = n + 1;
    end
    check(name, (fast === f && busy === 1'b0 && select === f) ? 1 : 0, 1);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    push_expected();
    #1;
    check("async_reset_outputs", int'({select, fast, busy, err}), 0);
  endtask

  // Monitor: compares DUT outputs with the queued expectation every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks = checks + 1;
        if (select !== e.sel || fast !== e.fst || busy !== e.bsy || err !== e.er) begin
          errors = errors + 1;
          $display("FAIL outputs t=%0t: select/fast/busy/err got %b%b%b%b, expected %b%b%b%b",
                   $time, select, fast, busy, err, e.sel, e.fst, e.bsy, e.er);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int n, t_a1, busy_cnt, coinc;
    bit a1_before, sel_seen, pred, saw;

    model_reset();

    // Reset, then 20 idle cycles
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (20) cycle();

    // Slow to fast with the bus idle; measure active1 -> fast latency
    req_fast = 1'b1;
    t_a1 = -100;
    n = 0;
    while (!(fast === 1'b1) && n < 100) begin
      a1_before = active1;
      cycle();
      n = n + 1;
      if (!a1_before && active1) t_a1 = cyc;
    end
    check("fast_reached", int'(fast), 1);
    check("active1_to_fast_latency", cyc - t_a1, SYNC_STAGES + 1);
    check("busy_falls_with_fast", int'(busy), 0);
    repeat (5) cycle();

    // force_slow overrides req_fast while in FAST
    force_slow = 1'b1;
    for (int i = 0; i < 10; i++) begin
      as_n = ($urandom_range(3, 0) != 0);
      cycle();
    end
    as_n = 1'b1;
    wait_settled("force_slow_to_slow", 1'b0, 100);
    repeat (10) cycle();
    check("fast_low_under_force_slow", int'(fast), 0);

    // Release override, back to fast; then ask for slow amid bus activity
    force_slow = 1'b0;
    wait_settled("back_to_fast", 1'b1, 100);
    req_fast = 1'b0;
    for (int i = 0; i < 20; i++) begin
      as_n = ($urandom_range(3, 0) != 0);
      cycle();
    end
    as_n = 1'b1;
    wait_settled("fast_to_slow", 1'b0, 100);

    // Idle gating: strobe pulses every 3 cycles hold off the launch
    as_n = 1'b0;
    repeat (3) cycle();
    req_fast = 1'b1;
    sel_seen = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      as_n = ((i % 3) == 0) ? 1'b0 : 1'b1;
      cycle();
      if (select === 1'b1) sel_seen = 1'b1;
    end
    check("select_held_while_pulsing", int'(sel_seen), 0);
    as_n = 1'b1;
    cycle();
    n = 0;
    while (!(select === 1'b1) && n < 50) begin
      cycle();
      n = n + 1;
    end
    check("idle_launch_latency", n, IDLE_CYCLES + SYNC_STAGES);
    wait_settled("gated_to_fast", 1'b1, 50);
    req_fast = 1'b0;
    wait_settled("gated_back_slow", 1'b0, 100);

    // Abort while arming: bus busy, request lasts 2 cycles
    as_n = 1'b0;
    repeat (4) cycle();
    busy_cnt = 0;
    sel_seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      req_fast = (j < 2);
      cycle();
      if (busy === 1'b1) busy_cnt = busy_cnt + 1;
      if (select === 1'b1) sel_seen = 1'b1;
    end
    check("abort_busy_cycles", busy_cnt, 2);
    check("abort_select_never", int'(sel_seen), 0);
    check("abort_back_to_slow", int'({select, fast, busy}), 0);
    as_n = 1'b1;
    repeat (6) cycle();

    // Timeout of a fast switch: mux frozen on clk0
    mux_stuck = 1;
    req_fast = 1'b1;
    n = 0;
    while (!(err === 1'b1) && n < 400) begin
      cycle();
      n = n + 1;
    end
    check("timeout_sets_err", int'(err), 1);
    check("timeout_reverts_select", int'(select), 0);
    check("timeout_enters_sw_s", int'(busy), 1);
    req_fast = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      cycle();
      n = n + 1;
    end
    check("revert_settles_slow", int'(busy), 0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("err_clr_clears", int'(err), 0);
    unstick();
    repeat (4) cycle();

    // Both switch states time out, each coinciding with an err_clr pulse
    mux_stuck = 2;
    req_fast = 1'b1;
    coinc = 0;
    saw = 1'b0;
    for (int k = 0; k < 800; k++) begin
      pred = (m_phase == 2) && (m_age == TIMEOUT);
      err_clr = pred;
      if (m_phase == 2) req_fast = 1'b0;
      cycle();
      if (pred) begin
        coinc = coinc + 1;
        check("timeout_beats_err_clr", int'(err), 1);
      end
      if (busy === 1'b1) saw = 1'b1;
      if (saw && busy === 1'b0) break;
    end
    err_clr = 1'b0;
    check("coincident_timeouts", coinc, 2);
    check("sw_s_timeout_to_slow", int'({select, fast, busy}), 0);
    unstick();
    repeat (4) cycle();

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(19, 0) == 0) req_fast = ~req_fast;
      if ($urandom_range(29, 0) == 0) force_slow = ~force_slow;
      as_n    = ($urandom_range(3, 0) != 0);
      err_clr = ($urandom_range(39, 0) == 0);
      cycle();
    end
    err_clr = 1'b0;
    force_slow = 1'b0;
    req_fast = 1'b0;
    as_n = 1'b1;
    wait_settled("random_settle_slow", 1'b0, 200);

    // Reset asserted in the middle of a fast switch
    mux_stuck = 1;
    req_fast = 1'b1;
    n = 0;
    while (!(select === 1'b1 && busy === 1'b1) && n < 50) begin
      cycle();
      n = n + 1;
    end
    check("reached_sw_f", int'(select && busy), 1);
    mid_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    unstick();
    req_fast = 1'b0;
    repeat (30) cycle();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
